// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Holds the op codes, FSM state codes and the default datapath width.
package muldiv_unit_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  function automatic logic is_iterative(input logic [1:0] op);
    return (op == OP_MULTU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the control path and the multiply/divide unit.
interface muldiv_unit_if #(parameter int WIDTH = 8);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (output start, op, a, b, input hi, lo, busy, done);
  modport slave  (input start, op, a, b, output hi, lo, busy, done);

endinterface

// File: rtl/muldiv_unit_step.sv
// One iteration of shift-add multiply or restoring divide on a 2*WIDTH accumulator.
// MULTU accumulator is {partial product, multiplier}; DIVU accumulator is {remainder, quotient}.
module muldiv_step
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]         op_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] rem_sub_s;

  // Single-iteration datapath for both operations
  always_comb begin
    sum_s     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} +
                (acc_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
    // The shifted remainder needs one extra bit; the difference always fits WIDTH bits
    rem_sh_s  = acc_i[2*WIDTH-1:WIDTH-1];
    rem_sub_s = rem_sh_s[WIDTH-1:0] - operand_i;
    acc_o     = acc_i;
    case (op_i)
      OP_MULTU: acc_o = {sum_s, acc_i[WIDTH-1:1]};
      OP_DIVU: begin
        if (rem_sh_s >= {1'b0, operand_i}) begin
          acc_o = {rem_sub_s, acc_i[WIDTH-2:0], 1'b1};
        end else begin
          acc_o = {rem_sh_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
        end
      end
      default: acc_o = acc_i;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MULTU/DIVU with HI/LO result registers and MTHI/MTLO writes.
// One bit per cycle; results land in HI/LO only on the final iteration edge.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int CNTBITS = 3
) (
  input  logic clk,
  input  logic reset_n,
  muldiv_unit_if.slave bus
);

  logic [1:0]         state_q, state_d;
  logic [CNTBITS-1:0] cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, done_q;
  logic [2*WIDTH-1:0] step_acc_s;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_i      (op_q),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (step_acc_s)
  );

  // Next-state logic: accept in IDLE/DONE, iterate in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_RUN: begin
        acc_d = step_acc_s;
        if (cnt_q == {CNTBITS{1'b0}}) begin
          hi_d    = step_acc_s[2*WIDTH-1:WIDTH];
          lo_d    = step_acc_s[WIDTH-1:0];
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNTBITS'(1);
        end
      end
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start && is_iterative(bus.op)) begin
          op_d    = bus.op;
          cnt_d   = CNTBITS'(WIDTH - 1);
          state_d = ST_RUN;
          // Multiplier / dividend sits in the low half; the other operand is held aside
          if (bus.op == OP_MULTU) begin
            acc_d  = {{WIDTH{1'b0}}, bus.b};
            opnd_d = bus.a;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, bus.a};
            opnd_d = bus.b;
          end
        end else if (bus.start && (bus.op == OP_MTHI)) begin
          hi_d = bus.a;
        end else if (bus.start && (bus.op == OP_MTLO)) begin
          lo_d = bus.a;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNTBITS{1'b0}};
      op_q    <= OP_MULTU;
      acc_q   <= {(2*WIDTH){1'b0}};
      opnd_q  <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative unsigned multiply/divide unit with HI/LO result registers, directly downstream of the register file.
- Consumes the rs/rt read data (rd1/rd2) on a start pulse.
- Runs one bit per cycle.
- Holds the double-width product, or the quotient/remainder, in HI/LO for later move-from instructions.
- Control (decoder/FSM) drives start/op and stalls on busy.

Parameters:
WIDTH, 8, datapath width in bits; matches register-file data width
CNTBITS, 3, iteration counter width; must satisfy 2**CNTBITS >= WIDTH

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request operation; sampled on rising clk
op  input  2  00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO
a  input  WIDTH  operand A (rs data: multiplicand, dividend, or MTHI/MTLO source)
b  input  WIDTH  operand B (rt data: multiplier or divisor)
hi  output  WIDTH  HI register: product upper half, or remainder
lo  output  WIDTH  LO register: product lower half, or quotient
busy  output  1  high while an iterative operation is in progress
done  output  1  one-cycle pulse; hi/lo hold the new result during it

Behaviour:
- Reset (reset_n low, asynchronous, any state):
  - hi=0, lo=0, busy=0, done=0.
  - FSM to IDLE, counter=0, internal operand registers cleared.
  - An in-flight operation is aborted with no partial HI/LO update.
- FSM states: IDLE, RUN, DONE.
- Accepting an operation: start=1 in IDLE or DONE.
  - MULTU/DIVU: latch a, b and op; counter=WIDTH-1; go to RUN.
  - MTHI: hi<=a in one cycle. MTLO: lo<=a in one cycle.
  - MTHI/MTLO stay in IDLE (from DONE, go to IDLE) and raise no done or busy.
- start while in RUN is ignored; no queuing. Control must hold off until busy=0.
- RUN, busy=1, one iteration per cycle:
  - MULTU: shift-add. Accumulator is 2*WIDTH bits. Add multiplicand when the current multiplier LSB is 1, then shift right.
  - DIVU: restoring division. Shift {rem,quot} left 1. If rem >= divisor, subtract and set quot LSB=1.
  - At counter==0: perform the final iteration, write hi/lo on that edge, go to DONE. Otherwise decrement the counter.
- DONE: done=1, busy=0 for exactly one cycle. Go to IDLE, or to RUN if a new MULTU/DIVU start arrives.
- Timing: a start sampled at edge E gives busy=1 for the WIDTH cycles after E, then done=1 in the next cycle. Latency is start edge to done = WIDTH+1 cycles (9 at default).
- hi/lo change only:
  - on the final RUN edge, or
  - on an MTHI/MTLO accept, or
  - at reset.
  - They hold their previous values throughout RUN.
- Results:
  - MULTU: {hi,lo} = a*b, full 2*WIDTH bits, no truncation.
  - DIVU: lo = a/b, hi = a mod b.
- Divide by zero (b=0) is not trapped and uses the same latency: lo = all ones, hi = a.
- Operands are unsigned; no signed variants in this block.
- Operands are latched at accept, so later changes on a/b during RUN have no effect.

Decomposition:
- Shared package holds:
  - op encodings (OP_MULTU, OP_DIVU, OP_MTHI, OP_MTLO);
  - FSM state encoding (ST_IDLE, ST_RUN, ST_DONE);
  - default WIDTH.
- One sub-module is natural: muldiv_step. It is combinational single-iteration logic:
  - inputs: op, accumulator/remainder, operand;
  - output: next accumulator.
  - It allows isolated unit testing.
- FSM, counter and HI/LO registers stay in muldiv_unit.

Test Plan:
1. Reset low mid-RUN (start MULTU 200*200, assert reset_n=0 at cycle 4) -> hi=0, lo=0, busy=0, done=0 immediately. After release, no done pulse ever appears.
2. MULTU a=13 b=11 -> busy high 8 cycles, done pulse 9 cycles after start edge, hi=0x00 lo=0x8F. MULTU 200*200 -> hi=0x9C lo=0x40. MULTU 255*255 -> hi=0xFE lo=0x01.
3. DIVU a=200 b=7 -> lo=28 hi=4, done after 9 cycles. DIVU a=37 b=0 -> lo=0xFF hi=37.
4. Start DIVU 100/9 while RUN of MULTU 13*11, with a/b changed mid-RUN -> second start ignored. Result stays hi=0 lo=0x8F, with exactly one done pulse.
5. MTHI a=0x5A then MTLO a=0xA5 on consecutive cycles in IDLE -> hi=0x5A, lo=0xA5 one edge after each. busy and done stay 0.
6. Back-to-back: new MULTU 3*5 started in DONE cycle of previous op -> busy rises next cycle, second done 9 cycles later, lo=15 hi=0.
